gate_sweep_driver: RTL and testbench

Sequential stimulus-and-check stage that sits directly upstream of a small gate-level device under test, such as the 2-input AND gate. It drives every input combination onto the gate's input pins in ascending order and waits a programmable settle time. It then samples the gate output, compares it against a parameterised truth table, and reports a mismatch count plus the first failing vector. It replaces hand-written initial-block stimulus in gate benches with a reusable, synthesizable-style driver.

---
 rtl/gate_tb_pkg.sv | 17 +
 rtl/gate_sweep_driver_if.sv | 24 ++
 rtl/gate_sweep_timer.sv | 25 ++
 rtl/gate_sweep_driver.sv | 109 ++++++++++
 tb/tb_gate_sweep_driver.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/gate_tb_pkg.sv
// Shared types and truth-table constants for the gate sweep driver and the benches that use it.
package gate_tb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_CHECK  = 2'd2,
        ST_FINISH = 2'd3
    } sweep_state_t;

    // Bit k is the expected gate output for input vector k (bit 0 = A, bit 1 = B).
    localparam logic [3:0] FN_AND2  = 4'b1000;
    localparam logic [3:0] FN_OR2   = 4'b1110;
    localparam logic [3:0] FN_XOR2  = 4'b0110;
    localparam logic [3:0] FN_NAND2 = 4'b0111;

endpackage

// File: rtl/gate_sweep_driver_if.sv
// Control, stimulus and result signals between the sweep driver and the gate/bench around it.
interface gate_sweep_driver_if #(
    parameter int N_IN = 2
) ();
    logic            start;
    logic            y;
    logic [N_IN-1:0] vec;
    logic            busy;
    logic            done;
    logic            pass;
    logic [N_IN:0]   err_cnt;
    logic [N_IN-1:0] fail_vec;

    // master is the driver itself; slave is whoever starts it and owns the gate.
    modport master (
        input  start, y,
        output vec, busy, done, pass, err_cnt, fail_vec
    );

    modport slave (
        output start, y,
        input  vec, busy, done, pass, err_cnt, fail_vec
    );
endinterface

// File: rtl/gate_sweep_timer.sv
// Loadable down-counter with a zero flag, used to time the settle interval of each vector.
module gate_sweep_timer #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);
    logic [W-1:0] count;

    // Load wins over counting; the counter parks at zero once it gets there.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);
endmodule

// File: rtl/gate_sweep_driver.sv
// Sweeps every input vector onto a small gate, checks Y against GATE_FN and reports errors.
// Define GATE_SWEEP_STOP_ON_FAIL_EN to end the sweep at the first mismatching vector.
module gate_sweep_driver
    import gate_tb_pkg::*;
#(
    parameter int                 N_IN    = 2,
    parameter int                 SETTLE  = 2,
    parameter logic [2**N_IN-1:0] GATE_FN = 4'b1000
) (
    input logic                clk,
    input logic                rst_n,
    gate_sweep_driver_if.master bus
);
    localparam int              CW       = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CW-1:0]   RELOAD   = CW'(SETTLE - 1);
    localparam logic [N_IN-1:0] LAST_VEC = '1;

    sweep_state_t    state, state_n;
    logic [N_IN-1:0] vec_q, vec_n;
    logic [N_IN:0]   err_q, err_n;
    logic [N_IN-1:0] fail_q, fail_n;
    logic            load;
    logic            zero;
    logic            mismatch;

    gate_sweep_timer #(.W(CW)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load),
        .load_val (RELOAD),
        .zero     (zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            vec_q  <= '0;
            err_q  <= '0;
            fail_q <= '0;
        end else begin
            state  <= state_n;
            vec_q  <= vec_n;
            err_q  <= err_n;
            fail_q <= fail_n;
        end
    end

    // Case-inequality so an X or Z on the gate output is treated as a failure.
    assign mismatch = (bus.y !== GATE_FN[vec_q]);

    always_comb begin
        state_n = state;
        vec_n   = vec_q;
        err_n   = err_q;
        fail_n  = fail_q;
        load    = 1'b0;
        unique case (state)
            ST_IDLE, ST_FINISH: begin
                if (bus.start) begin
                    state_n = ST_SETTLE;
                    vec_n   = '0;
                    err_n   = '0;
                    fail_n  = '0;
                    load    = 1'b1;
                end
            end
            ST_SETTLE: begin
                if (zero) begin
                    state_n = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (mismatch) begin
                    err_n = err_q + 1'b1;
                    if (err_q == '0) begin
                        fail_n = vec_q;
                    end
                end
`ifdef GATE_SWEEP_STOP_ON_FAIL_EN
                if (mismatch || (vec_q == LAST_VEC)) begin
                    state_n = ST_FINISH;
                end else begin
                    state_n = ST_SETTLE;
                    vec_n   = vec_q + 1'b1;
                    load    = 1'b1;
                end
`else
                if (vec_q == LAST_VEC) begin
                    state_n = ST_FINISH;
                end else begin
                    state_n = ST_SETTLE;
                    vec_n   = vec_q + 1'b1;
                    load    = 1'b1;
                end
`endif
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    assign bus.vec      = vec_q;
    assign bus.busy     = (state == ST_SETTLE) || (state == ST_CHECK);
    assign bus.done     = (state == ST_FINISH);
    assign bus.pass     = (state == ST_FINISH) && (err_q == '0);
    assign bus.err_cnt  = err_q;
    assign bus.fail_vec = fail_q;
endmodule

// File: tb/tb_gate_sweep_driver.sv
// Directed bench for gate_sweep_driver: a 2-input AND sweep with selectable gate faults and a 3-input sweep.
module tb_gate_sweep_driver;
    import gate_tb_pkg::*;

    logic clk;
    logic rst_n;
    int   y_mode;
    int   total;
    int   bad;

    gate_sweep_driver_if #(.N_IN(2)) bus0 ();
    gate_sweep_driver_if #(.N_IN(3)) bus1 ();

    gate_sweep_driver #(.N_IN(2), .SETTLE(2), .GATE_FN(FN_AND2)) dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0)
    );

    gate_sweep_driver #(.N_IN(3), .SETTLE(1), .GATE_FN(8'b1000_0000)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Gate models: 0 = healthy AND, 1 = output stuck at 0, 2 = output stuck at 1.
    always_comb begin
        case (y_mode)
            1:       bus0.y = 1'b0;
            2:       bus0.y = 1'b1;
            default: bus0.y = &bus0.vec;
        endcase
        bus1.y = &bus1.vec;
    end

    task automatic run_sweep0(output int edges);
        @(negedge clk);
        bus0.start = 1'b1;
        @(posedge clk);
        #1;
        bus0.start = 1'b0;
        edges = -1;
        for (int k = 1; k <= 100; k++) begin
            @(posedge clk);
            #1;
            if (bus0.done === 1'b1) begin
                edges = k;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus0.start = 1'b0;
        bus1.start = 1'b0;
        y_mode = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        if (bus0.vec !== 2'd0) begin bad++; $display("[TB] FAIL reset_vec: got %0d want 0", bus0.vec); end
        total++;
        if (bus0.busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy: got %b want 0", bus0.busy); end
        total++;
        if (bus0.done !== 1'b0) begin bad++; $display("[TB] FAIL reset_done: got %b want 0", bus0.done); end
        total++;
        if (bus0.pass !== 1'b0) begin bad++; $display("[TB] FAIL reset_pass: got %b want 0", bus0.pass); end
        total++;
        if (bus0.err_cnt !== 3'd0) begin bad++; $display("[TB] FAIL reset_err: got %0d want 0", bus0.err_cnt); end
        total++;
        if (bus0.fail_vec !== 2'd0) begin bad++; $display("[TB] FAIL reset_fvec: got %0d want 0", bus0.fail_vec); end
        total++;
    endtask

    task automatic test_default_and();
        int edges;
        y_mode = 0;
        @(negedge clk);
        bus0.start = 1'b1;
        @(posedge clk);
        #1;
        bus0.start = 1'b0;
        if (bus0.busy !== 1'b1) begin bad++; $display("[TB] FAIL start_busy: got %b want 1", bus0.busy); end
        total++;
        edges = -1;
        for (int k = 0; k <= 100; k++) begin
            if (k > 0) begin
                @(posedge clk);
                #1;
            end
            if (bus0.done === 1'b1) begin
                edges = k;
                break;
            end
            // Each vector is held for three edges: two settle cycles then the check cycle.
            if (bus0.vec !== 2'(k / 3)) begin
                bad++;
                $display("[TB] FAIL vec_step_%0d: got %0d want %0d", k, bus0.vec, k / 3);
            end
            total++;
        end
        if (edges !== 12) begin bad++; $display("[TB] FAIL and_done_edge: got %0d want 12", edges); end
        total++;
        if (bus0.err_cnt !== 3'd0) begin bad++; $display("[TB] FAIL and_err: got %0d want 0", bus0.err_cnt); end
        total++;
        if (bus0.pass !== 1'b1) begin bad++; $display("[TB] FAIL and_pass: got %b want 1", bus0.pass); end
        total++;
        if (bus0.busy !== 1'b0) begin bad++; $display("[TB] FAIL and_busy_end: got %b want 0", bus0.busy); end
        total++;
        if (bus0.vec !== 2'd3) begin bad++; $display("[TB] FAIL and_vec_hold: got %0d want 3", bus0.vec); end
        total++;
    endtask

    task automatic test_stuck0();
        int edges;
        y_mode = 1;
        run_sweep0(edges);
        if (edges !== 12) begin bad++; $display("[TB] FAIL s0_done_edge: got %0d want 12", edges); end
        total++;
        if (bus0.err_cnt !== 3'd1) begin bad++; $display("[TB] FAIL s0_err: got %0d want 1", bus0.err_cnt); end
        total++;
        if (bus0.fail_vec !== 2'd3) begin bad++; $display("[TB] FAIL s0_fvec: got %0d want 3", bus0.fail_vec); end
        total++;
        if (bus0.pass !== 1'b0) begin bad++; $display("[TB] FAIL s0_pass: got %b want 0", bus0.pass); end
        total++;
    endtask

    task automatic test_stuck1();
        int edges;
        int exp_edges;
        int exp_err;
        y_mode = 2;
`ifdef GATE_SWEEP_STOP_ON_FAIL_EN
        exp_edges = 3;
        exp_err = 1;
`else
        exp_edges = 12;
        exp_err = 3;
`endif
        run_sweep0(edges);
        if (edges !== exp_edges) begin bad++; $display("[TB] FAIL s1_done_edge: got %0d want %0d", edges, exp_edges); end
        total++;
        if (int'(bus0.err_cnt) !== exp_err) begin bad++; $display("[TB] FAIL s1_err: got %0d want %0d", bus0.err_cnt, exp_err); end
        total++;
        if (bus0.fail_vec !== 2'd0) begin bad++; $display("[TB] FAIL s1_fvec: got %0d want 0", bus0.fail_vec); end
        total++;
        if (bus0.pass !== 1'b0) begin bad++; $display("[TB] FAIL s1_pass: got %b want 0", bus0.pass); end
        total++;
        // Results must stay frozen while sitting in FINISH.
        repeat (3) @(posedge clk);
        #1;
        if (int'(bus0.err_cnt) !== exp_err) begin bad++; $display("[TB] FAIL s1_err_hold: got %0d want %0d", bus0.err_cnt, exp_err); end
        total++;
    endtask

    task automatic test_back_to_back();
        int edges;
        y_mode = 0;
        @(negedge clk);
        bus0.start = 1'b1;
        @(posedge clk);
        #1;
        bus0.start = 1'b0;
        if (bus0.err_cnt !== 3'd0) begin bad++; $display("[TB] FAIL b2b_err_clr: got %0d want 0", bus0.err_cnt); end
        total++;
        if (bus0.done !== 1'b0) begin bad++; $display("[TB] FAIL b2b_done_clr: got %b want 0", bus0.done); end
        total++;
        if (bus0.vec !== 2'd0) begin bad++; $display("[TB] FAIL b2b_vec0: got %0d want 0", bus0.vec); end
        total++;
        edges = -1;
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            bus0.start = (k == 4);
            @(posedge clk);
            #1;
            if (bus0.done === 1'b1) begin
                edges = k;
                break;
            end
        end
        bus0.start = 1'b0;
        if (edges !== 12) begin bad++; $display("[TB] FAIL b2b_done_edge: got %0d want 12", edges); end
        total++;
        if (bus0.pass !== 1'b1) begin bad++; $display("[TB] FAIL b2b_pass: got %b want 1", bus0.pass); end
        total++;
    endtask

    task automatic test_reset_mid();
        int cnt;
        y_mode = 0;
        @(negedge clk);
        bus0.start = 1'b1;
        @(posedge clk);
        #1;
        bus0.start = 1'b0;
        cnt = 0;
        while ((bus0.vec !== 2'd2) && (cnt < 50)) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        if (bus0.vec !== 2'd2) begin bad++; $display("[TB] FAIL rst_reach_vec2: got %0d want 2", bus0.vec); end
        total++;
        #1;
        rst_n = 1'b0;
        #1;
        if (bus0.vec !== 2'd0) begin bad++; $display("[TB] FAIL rst_async_vec: got %0d want 0", bus0.vec); end
        total++;
        if (bus0.busy !== 1'b0) begin bad++; $display("[TB] FAIL rst_async_busy: got %b want 0", bus0.busy); end
        total++;
        if (bus0.done !== 1'b0) begin bad++; $display("[TB] FAIL rst_async_done: got %b want 0", bus0.done); end
        total++;
        if (bus0.err_cnt !== 3'd0) begin bad++; $display("[TB] FAIL rst_async_err: got %0d want 0", bus0.err_cnt); end
        total++;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        if (bus0.done !== 1'b0) begin bad++; $display("[TB] FAIL rst_no_done: got %b want 0", bus0.done); end
        total++;
        if (bus0.busy !== 1'b0) begin bad++; $display("[TB] FAIL rst_stay_idle: got %b want 0", bus0.busy); end
        total++;
    endtask

    task automatic test_and3();
        int edges;
        @(negedge clk);
        bus1.start = 1'b1;
        @(posedge clk);
        #1;
        bus1.start = 1'b0;
        edges = -1;
        for (int k = 1; k <= 100; k++) begin
            @(posedge clk);
            #1;
            if (bus1.done === 1'b1) begin
                edges = k;
                break;
            end
        end
        if (edges !== 16) begin bad++; $display("[TB] FAIL and3_done_edge: got %0d want 16", edges); end
        total++;
        if (bus1.pass !== 1'b1) begin bad++; $display("[TB] FAIL and3_pass: got %b want 1", bus1.pass); end
        total++;
        if (bus1.err_cnt !== 4'd0) begin bad++; $display("[TB] FAIL and3_err: got %0d want 0", bus1.err_cnt); end
        total++;
        if (bus1.vec !== 3'd7) begin bad++; $display("[TB] FAIL and3_vec_last: got %0d want 7", bus1.vec); end
        total++;
    endtask

    initial begin
        total = 0;
        bad = 0;
        test_reset();
        test_default_and();
        test_stuck0();
        test_stuck1();
        test_back_to_back();
        test_reset_mid();
        test_and3();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
